// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: select/state codes shared by the Tx controller and the Tx mux.
// The controller state register carries these codes directly as Mux_Sel.
package uart_tx_pkg;

   localparam int unsigned SEL_W = 3;

   typedef enum logic [SEL_W-1:0] {
      SEL_IDLE   = 3'b000,
      SEL_START  = 3'b001,
      SEL_DATA   = 3'b010,
      SEL_PARITY = 3'b011,
      SEL_STOP   = 3'b100
   } tx_sel_e;

   function automatic logic sel_is_busy(input tx_sel_e s);
      return s != SEL_IDLE;
   endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: byte request in, per-bit mux controls out.
// master = byte source / mux side, slave = uart_tx_ctrl.
interface uart_tx_ctrl_if
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [SEL_W-1:0]      Mux_Sel;
   logic                  S_DATA;
   logic                  Parity_Bit;
   logic                  Busy;

   modport master (
      output P_DATA,
      output Data_Valid,
      output PAR_EN,
      output PAR_TYP,
      input  Mux_Sel,
      input  S_DATA,
      input  Parity_Bit,
      input  Busy
   );

   modport slave (
      input  P_DATA,
      input  Data_Valid,
      input  PAR_EN,
      input  PAR_TYP,
      output Mux_Sel,
      output S_DATA,
      output Parity_Bit,
      output Busy
   );

endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: payload shift register (LSB first) and bit counter.
// Ports: clk, rst_n, load, enable, P_DATA in; S_DATA, ser_done out.
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  S_DATA,
   output logic                  ser_done
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   assign ser_done = enable && (cnt_q == LAST);
   assign S_DATA   = shift_q[0];

   // Counter is cleared on the last bit so it never wraps for widths
   // that are not a power of two.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (load) begin
         shift_d = P_DATA;
         cnt_d   = '0;
      end else if (enable) begin
         shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
         cnt_d   = ser_done ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: sequences start/data/parity/stop, one bit per CLK.
// Ports: CLK, RST (async, active-low), bus (slave: request in, mux controls out).
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input logic           CLK,
   input logic           RST,
   uart_tx_ctrl_if.slave bus
);

   tx_sel_e state_q, state_d;
   logic    par_q, par_d;
   logic    par_en_q, par_en_d;
   logic    accept;
   logic    ser_en;
   logic    ser_done;
   logic    ser_bit;

   assign accept = (state_q == SEL_IDLE) && bus.Data_Valid;
   assign ser_en = (state_q == SEL_DATA);

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ser (
      .clk      (CLK),
      .rst_n    (RST),
      .load     (accept),
      .enable   (ser_en),
      .P_DATA   (bus.P_DATA),
      .S_DATA   (ser_bit),
      .ser_done (ser_done)
   );

   // Frame options and parity are captured once, so request-side
   // changes mid-frame cannot disturb the frame in flight.
   always_comb begin
      par_d    = par_q;
      par_en_d = par_en_q;
      if (accept) begin
         par_en_d = bus.PAR_EN;
         par_d    = bus.PAR_TYP ? ~^bus.P_DATA : ^bus.P_DATA;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SEL_IDLE:   if (bus.Data_Valid) state_d = SEL_START;
         SEL_START:  state_d = SEL_DATA;
         SEL_DATA: begin
            if (ser_done)
               state_d = par_en_q ? SEL_PARITY : SEL_STOP;
         end
         SEL_PARITY: state_d = SEL_STOP;
         SEL_STOP:   state_d = SEL_IDLE;
         default:    state_d = SEL_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= SEL_IDLE;
         par_q    <= 1'b0;
         par_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         par_q    <= par_d;
         par_en_q <= par_en_d;
      end
   end

   assign bus.Mux_Sel    = state_q;
   assign bus.Busy       = sel_is_busy(state_q);
   assign bus.S_DATA     = ser_bit;
   assign bus.Parity_Bit = par_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed frame vectors plus reset, back-to-back,
// ignored-request and illegal-state sequences for uart_tx_ctrl.
module tb_uart_tx_ctrl;
   import uart_tx_pkg::*;

   typedef struct {
      logic [7:0] data;
      logic       par_en;
      logic       par_typ;
      logic       exp_par;
      int         exp_len;
      logic       noisy;
   } vec_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   uart_tx_ctrl_if bus ();

   uart_tx_ctrl dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic start_frame(input vec_t v);
      bus.P_DATA     = v.data;
      bus.PAR_EN     = v.par_en;
      bus.PAR_TYP    = v.par_typ;
      bus.Data_Valid = 1'b1;
      chk("pre_idle", 32'(bus.Mux_Sel), 32'(0));
      tick();
      bus.Data_Valid = 1'b0;
   endtask

   // Walks one frame starting in START; inputs are disturbed every cycle
   // according to hold_dv / mid_data / v.noisy.
   task automatic walk(input vec_t v, input logic hold_dv,
                       input logic [7:0] mid_data);
      logic [2:0] es;
      int nb;
      int busy_n;
      nb = v.par_en ? 11 : 10;
      busy_n = 0;
      for (int k = 0; k < nb; k++) begin
         if (k == 0) es = 3'b001;
         else if (k <= 8) es = 3'b010;
         else if (v.par_en && k == 9) es = 3'b011;
         else es = 3'b100;
         chk("mux_sel", 32'(bus.Mux_Sel), 32'(es));
         if (es == 3'b010)
            chk("s_data", 32'(bus.S_DATA), 32'(v.data[k-1]));
         if (es == 3'b011)
            chk("parity_bit", 32'(bus.Parity_Bit), 32'(v.exp_par));
         if (bus.Busy) busy_n++;
         bus.Data_Valid = hold_dv;
         bus.P_DATA     = mid_data;
         if (v.noisy) begin
            bus.PAR_EN  = ~v.par_en;
            bus.PAR_TYP = ~v.par_typ;
         end
         tick();
      end
      chk("busy_len", 32'(busy_n), 32'(v.exp_len));
      chk("idle_after", 32'(bus.Mux_Sel), 32'(0));
      chk("busy_after", 32'(bus.Busy), 32'(0));
      chk("parity_hold", 32'(bus.Parity_Bit), 32'(v.exp_par));
   endtask

   vec_t tbl[10];
   vec_t va, vb;

   initial begin
      tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11, 1'b0};
      tbl[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 11, 1'b0};
      tbl[2] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10, 1'b0};
      tbl[3] = '{8'h3C, 1'b1, 1'b0, 1'b0, 11, 1'b1};
      tbl[4] = '{8'h01, 1'b1, 1'b0, 1'b1, 11, 1'b0};
      tbl[5] = '{8'h01, 1'b1, 1'b1, 1'b0, 11, 1'b1};
      tbl[6] = '{8'hFF, 1'b0, 1'b0, 1'b0, 10, 1'b1};
      tbl[7] = '{8'h00, 1'b1, 1'b1, 1'b1, 11, 1'b0};
      tbl[8] = '{8'h7F, 1'b1, 1'b0, 1'b1, 11, 1'b0};
      tbl[9] = '{8'h80, 1'b0, 1'b1, 1'b0, 10, 1'b1};

      bus.P_DATA     = 8'h00;
      bus.Data_Valid = 1'b0;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;

      #2 RST = 1'b0;
      #1;
      chk("rst_mux_sel", 32'(bus.Mux_Sel), 32'(0));
      chk("rst_busy", 32'(bus.Busy), 32'(0));
      chk("rst_s_data", 32'(bus.S_DATA), 32'(0));
      chk("rst_parity", 32'(bus.Parity_Bit), 32'(0));
      @(negedge CLK);
      RST = 1'b1;
      tick();

      for (int i = 0; i < 10; i++) begin
         start_frame(tbl[i]);
         walk(tbl[i], tbl[i].noisy,
              tbl[i].noisy ? ~tbl[i].data : tbl[i].data);
         bus.Data_Valid = 1'b0;
         tick();
         chk("no_extra", 32'(bus.Mux_Sel), 32'(0));
      end

      // Back-to-back with Data_Valid held and P_DATA swapped mid-frame.
      va = '{8'hA5, 1'b1, 1'b0, 1'b0, 11, 1'b0};
      vb = '{8'h3C, 1'b1, 1'b0, 1'b0, 11, 1'b0};
      start_frame(va);
      walk(va, 1'b1, 8'h3C);
      tick();
      walk(vb, 1'b0, 8'h3C);
      tick();
      chk("b2b_end", 32'(bus.Mux_Sel), 32'(0));

      // Reset in the middle of TRANSMIT_DATA.
      va = '{8'hA5, 1'b1, 1'b1, 1'b1, 11, 1'b0};
      start_frame(va);
      tick();
      tick();
      tick();
      chk("pre_rst_sel", 32'(bus.Mux_Sel), 32'(2));
      #2 RST = 1'b0;
      #1;
      chk("mid_rst_sel", 32'(bus.Mux_Sel), 32'(0));
      chk("mid_rst_busy", 32'(bus.Busy), 32'(0));
      chk("mid_rst_sdata", 32'(bus.S_DATA), 32'(0));
      chk("mid_rst_par", 32'(bus.Parity_Bit), 32'(0));
      @(negedge CLK);
      RST = 1'b1;
      tick();
      chk("post_rst_idle", 32'(bus.Mux_Sel), 32'(0));
      start_frame(va);
      walk(va, 1'b0, va.data);

      // Unreachable encoding returns to IDLE.
      force dut.state_q = tx_sel_e'(3'b101);
      #1;
      chk("bad_sel", 32'(bus.Mux_Sel), 32'(5));
      chk("bad_busy", 32'(bus.Busy), 32'(1));
      release dut.state_q;
      @(negedge CLK);
      chk("bad_recover", 32'(bus.Mux_Sel), 32'(0));
      chk("bad_busy_low", 32'(bus.Busy), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
